axi4l_mst: RTL and testbench

//  AXI4-Lite master (initiator) bridging the core load/store unit onto the AXI4-Lite slaves (iram, peripherals).

---
 rtl/axi4l_mst_if.sv | 39 +++
 rtl/axi4l_mst.sv | 113 +++++++++++
 tb/tb_axi4l_mst.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_mst_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) between one master and one slave.
// No clock or reset inside; both ends share the core clock domain.
interface axi4l_mst_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_mst.sv
// Single-outstanding AXI4-Lite master for the load/store unit; zero-wait slave gives done 3 cycles after request.
// Backpressure: requests are ignored while busy; AXI valids hold until their handshake or the hang timeout aborts.
module axi4l_mst #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_err_o,
    output logic        mem_busy_o,
    axi4l_mst_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, to_cnt;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, to_hit;
    logic        fin, fin_err, rd_lat;

    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_hs   = m_axi.wvalid & m_axi.wready;
    assign to_hit = (TO_LIM != 32'd0) && (to_cnt == TO_LIM - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        fin_err   = 1'b0;
        rd_lat    = 1'b0;
        case (state)
            IDLE:  if (mem_req_i) state_nxt = mem_we_i ? WRITE : RADDR;
            WRITE: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WRESP;
            WRESP: if (m_axi.bvalid) begin
                state_nxt = IDLE;
                fin       = 1'b1;
                fin_err   = (m_axi.bresp != 2'b00);
            end
            RADDR: if (m_axi.arready) state_nxt = RDATA;
            RDATA: if (m_axi.rvalid) begin
                state_nxt = IDLE;
                fin       = 1'b1;
                fin_err   = (m_axi.rresp != 2'b00);
                rd_lat    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // A B/R handshake in the timeout cycle completes normally
        if (state != IDLE && !fin && to_hit) begin
            state_nxt = IDLE;
            fin       = 1'b1;
            fin_err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            to_cnt      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            mem_err_o   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (mem_req_i) begin
                    addr_q  <= mem_addr_i;
                    wdata_q <= mem_wdata_i;
                    wstrb_q <= mem_wstrb_i;
                    to_cnt  <= '0;
                end
            end else begin
                to_cnt <= to_cnt + 32'd1;
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (rd_lat) mem_rdata_o <= m_axi.rdata;
            mem_done_o <= fin;
            mem_err_o  <= fin & fin_err;
        end
    end

    assign mem_busy_o    = (state != IDLE);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = (state == WRITE) & ~aw_done;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = (state == WRITE) & ~w_done;
    assign m_axi.bready  = (state == WRESP);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state == RADDR);
    assign m_axi.rready  = (state == RDATA);
endmodule

// File: tb/tb_axi4l_mst.sv
// Bench for axi4l_mst: configurable slave model, completions checked against an expectation queue.
module tb_axi4l_mst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_wstrb_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o, mem_err_o, mem_busy_o;

    axi4l_mst_if ax ();

    axi4l_mst #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .mem_err_o(mem_err_o), .mem_busy_o(mem_busy_o),
        .m_axi(ax)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model configuration and observation
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit          ar_never = 0, b_hold = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    int          aw_beats = 0, w_beats = 0, ar_beats = 0;
    int          awv_cyc = 0, wv_cyc = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    initial begin
        ax.awready = 1'b0; ax.wready = 1'b0; ax.bvalid = 1'b0; ax.bresp = 2'b00;
        ax.arready = 1'b0; ax.rvalid = 1'b0; ax.rresp = 2'b00; ax.rdata = '0;
    end

    always @(negedge clk) begin
        if (ax.awvalid) begin aw_wait++; awv_cyc++; end else aw_wait = 0;
        if (ax.wvalid)  begin w_wait++;  wv_cyc++;  end else w_wait = 0;
        if (ax.arvalid) ar_wait++; else ar_wait = 0;
        ax.awready = ax.awvalid && (aw_wait > aw_delay);
        ax.wready  = ax.wvalid && (w_wait > w_delay);
        ax.arready = ax.arvalid && !ar_never && (ar_wait > ar_delay);
        ax.bvalid  = ax.bready && !b_hold;
        ax.bresp   = bresp_cfg;
        ax.rvalid  = ax.rready;
        ax.rresp   = rresp_cfg;
        ax.rdata   = rdata_cfg;
    end

    always @(posedge clk) begin
        if (ax.awvalid && ax.awready) begin aw_beats++; cap_awaddr = ax.awaddr; end
        if (ax.wvalid && ax.wready) begin w_beats++; cap_wdata = ax.wdata; cap_wstrb = ax.wstrb; end
        if (ax.arvalid && ax.arready) begin ar_beats++; cap_araddr = ax.araddr; end
    end

    task automatic clear_obs();
        aw_beats = 0; w_beats = 0; ar_beats = 0; awv_cyc = 0; wv_cyc = 0;
    endtask

    // Presents a request for one cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_wstrb_i = st;
        e.err = exp_err; e.rdata = exp_rd;
        exp_q.push_back(e);
        @(negedge clk);
        mem_req_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit found);
        found = 0; cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            if (mem_done_o) begin found = 1; cyc = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({mem_done_o, mem_err_o, mem_busy_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {mem_done_o, mem_err_o, mem_busy_o}); end
        n_cmp++; if ({ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready} !== 5'b0) begin n_bad++; $display("FAIL reset_axi_ctl: got %b expected 00000", {ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready}); end
        n_cmp++; if ({ax.awaddr, ax.wdata, mem_rdata_o} !== 96'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {ax.awaddr, ax.wdata, mem_rdata_o}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        int cyc; bit found; exp_t e;
        clear_obs(); aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        n_cmp++; if ({ax.awvalid, ax.wvalid, mem_busy_o} !== 3'b111) begin n_bad++; $display("FAIL wr_cycle1_valid: got %b expected 111", {ax.awvalid, ax.wvalid, mem_busy_o}); end
        wait_done(20, cyc, found);
        n_cmp++; if (!found || cyc != 3) begin n_bad++; $display("FAIL wr_latency: got found=%0d cycle=%0d expected cycle 3", found, cyc); end
        e = exp_q.pop_front();
        n_cmp++; if (mem_err_o !== e.err) begin n_bad++; $display("FAIL wr_err: got %b expected %b", mem_err_o, e.err); end
        n_cmp++; if (mem_busy_o !== 1'b0) begin n_bad++; $display("FAIL wr_busy_on_done: got %b expected 0", mem_busy_o); end
        n_cmp++; if ({cap_awaddr, cap_wdata, cap_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin n_bad++; $display("FAIL wr_payload: got %h %h %h expected 10 deadbeef f", cap_awaddr, cap_wdata, cap_wstrb); end
        @(negedge clk);
        n_cmp++; if (mem_done_o !== 1'b0) begin n_bad++; $display("FAIL wr_done_pulse: got %b expected 0", mem_done_o); end
    endtask

    task automatic test_write_lag();
        int cyc; bit found; exp_t e;
        clear_obs(); aw_delay = 0; w_delay = 3;
        issue(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h3, 1'b0, 32'h0);
        wait_done(30, cyc, found);
        n_cmp++; if (!found || cyc != 6) begin n_bad++; $display("FAIL wlag_latency: got found=%0d cycle=%0d expected cycle 6", found, cyc); end
        e = exp_q.pop_front();
        n_cmp++; if (mem_err_o !== e.err) begin n_bad++; $display("FAIL wlag_err: got %b expected %b", mem_err_o, e.err); end
        n_cmp++; if (awv_cyc != 1 || wv_cyc != 4) begin n_bad++; $display("FAIL wlag_valid_cycles: got aw=%0d w=%0d expected aw=1 w=4", awv_cyc, wv_cyc); end
        n_cmp++; if (aw_beats != 1 || w_beats != 1) begin n_bad++; $display("FAIL wlag_beats: got aw=%0d w=%0d expected 1 1", aw_beats, w_beats); end
        n_cmp++; if ({cap_wdata, cap_wstrb} !== {32'h0BADF00D, 4'h3}) begin n_bad++; $display("FAIL wlag_payload: got %h %h expected 0badf00d 3", cap_wdata, cap_wstrb); end
        w_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_read_delay();
        int cyc; bit found; exp_t e;
        clear_obs(); ar_delay = 2; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
        issue(1'b0, 32'h0800_0004, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        wait_done(30, cyc, found);
        n_cmp++; if (!found || cyc != 5) begin n_bad++; $display("FAIL rd_latency: got found=%0d cycle=%0d expected cycle 5", found, cyc); end
        e = exp_q.pop_front();
        n_cmp++; if (mem_rdata_o !== e.rdata || mem_err_o !== e.err) begin n_bad++; $display("FAIL rd_data: got %h err=%b expected %h err=%b", mem_rdata_o, mem_err_o, e.rdata, e.err); end
        n_cmp++; if (cap_araddr !== 32'h0800_0004 || ar_beats != 1) begin n_bad++; $display("FAIL rd_addr: got %h beats=%0d expected 08000004 beats=1", cap_araddr, ar_beats); end
        ar_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_err_resp();
        int cyc; bit found; exp_t e;
        rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b10;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);
        wait_done(20, cyc, found);
        e = exp_q.pop_front();
        n_cmp++; if (!found || mem_err_o !== e.err || mem_rdata_o !== e.rdata) begin n_bad++; $display("FAIL rd_slverr: got found=%0d err=%b data=%h expected err=%b data=%h", found, mem_err_o, mem_rdata_o, e.err, e.rdata); end
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        @(negedge clk);
        issue(1'b1, 32'h0000_0044, 32'h5555_AAAA, 4'hC, 1'b1, 32'h0);
        wait_done(20, cyc, found);
        e = exp_q.pop_front();
        n_cmp++; if (!found || mem_err_o !== e.err) begin n_bad++; $display("FAIL wr_decerr: got found=%0d err=%b expected err=%b", found, mem_err_o, e.err); end
        n_cmp++; if (mem_rdata_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rdata_hold: got %h expected cafef00d", mem_rdata_o); end
        bresp_cfg = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc; bit found; exp_t e;
        clear_obs(); ar_never = 1;
        issue(1'b0, 32'h0000_0080, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);
        n_cmp++; if (mem_busy_o !== 1'b1 || ax.arvalid !== 1'b1) begin n_bad++; $display("FAIL to_start: got busy=%b arvalid=%b expected 1 1", mem_busy_o, ax.arvalid); end
        wait_done(40, cyc, found);
        n_cmp++; if (!found || cyc != 17) begin n_bad++; $display("FAIL to_latency: got found=%0d cycle=%0d expected cycle 17", found, cyc); end
        e = exp_q.pop_front();
        n_cmp++; if (mem_err_o !== e.err || mem_rdata_o !== e.rdata) begin n_bad++; $display("FAIL to_result: got err=%b data=%h expected err=%b data=%h", mem_err_o, mem_rdata_o, e.err, e.rdata); end
        n_cmp++; if (ax.arvalid !== 1'b0 || mem_busy_o !== 1'b0) begin n_bad++; $display("FAIL to_release: got arvalid=%b busy=%b expected 0 0", ax.arvalid, mem_busy_o); end
        ar_never = 0;
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cyc; bit found; int extra; exp_t e;
        clear_obs();
        exp_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0200; mem_wdata_i = 32'h1111_2222; mem_wstrb_i = 4'hF;
        @(negedge clk);
        wait_done(20, cyc, found);
        mem_req_i = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (!found || mem_err_o !== e.err) begin n_bad++; $display("FAIL busy_done: got found=%0d err=%b expected err=%b", found, mem_err_o, e.err); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (mem_done_o || mem_busy_o) extra++; end
        n_cmp++; if (aw_beats != 1 || w_beats != 1 || extra != 0) begin n_bad++; $display("FAIL busy_single: got aw=%0d w=%0d extra=%0d expected 1 1 0", aw_beats, w_beats, extra); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit found; exp_t e;
        rdata_cfg = 32'hA5A5_0001;
        issue(1'b1, 32'h0000_0300, 32'h7777_8888, 4'hF, 1'b0, 32'hCAFE_F00D);
        wait_done(20, cyc, found);
        e = exp_q.pop_front();
        n_cmp++; if (!found || mem_err_o !== e.err) begin n_bad++; $display("FAIL b2b_first: got found=%0d err=%b expected err=%b", found, mem_err_o, e.err); end
        issue(1'b0, 32'h0000_0304, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001);
        wait_done(20, cyc, found);
        e = exp_q.pop_front();
        n_cmp++; if (!found || cyc != 3 || mem_rdata_o !== e.rdata) begin n_bad++; $display("FAIL b2b_second: got found=%0d cycle=%0d data=%h expected cycle 3 data=%h", found, cyc, mem_rdata_o, e.rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones;
        b_hold = 1;
        issue(1'b1, 32'h0000_0400, 32'h9999_0000, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        n_cmp++; if (ax.bready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_wresp: got bready=%b expected 1", ax.bready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({ax.bready, mem_busy_o, ax.awvalid, ax.wvalid, mem_done_o} !== 5'b0) begin n_bad++; $display("FAIL rmid_ctl: got %b expected 00000", {ax.bready, mem_busy_o, ax.awvalid, ax.wvalid, mem_done_o}); end
        n_cmp++; if ({ax.awaddr, ax.wdata, mem_rdata_o} !== 96'h0) begin n_bad++; $display("FAIL rmid_data: got %h expected 0", {ax.awaddr, ax.wdata, mem_rdata_o}); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1; b_hold = 0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (mem_done_o || mem_busy_o) dones++; end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d activity cycles expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_lag();
        test_read_delay();
        test_err_resp();
        test_timeout();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
